// File: rtl/sqrt_controller.sv
//------------------------------------------------------------------------------
// sqrt_controller
//
// Sequencing FSM for the single/double-precision square-root datapath.
//
// A start request in IDLE produces a combinational load pulse to the input
// wrapper's operand registers. It also latches the operand type and flags.
// Normal operands (run=1) go through INIT and then ITER. ITER lasts for a
// type-dependent number of digit-recurrence iterations. After ITER the FSM
// passes through WB, which loads the result register. Special operands
// (run=0) take the one-cycle SPECIAL bypass instead. The result register
// then loads from the special-value path. In both cases the FSM parks in HOLD
// and presents valid until the consumer takes the result with out_ready.
//
// Parameters
//    DP_ITER      core iterations for double precision (in_type=1)
//    SP_ITER      core iterations for single precision (in_type=0)
//    CNT_W        iteration counter width, 2**CNT_W > max(DP_ITER, SP_ITER)
//
// Ports
//    clk          clock
//    rst          synchronous active-high reset
//    start        request a new operation (sampled in IDLE only)
//    run          1 = normal positive operand, use the core
//    in_type      0 = single, 1 = double
//    in_flags     wrapper class code (000 denormal, 001 zero, 010 inf,
//                 011 nan, 100 normal, 111 sign error)
//    out_ready    downstream accepts the result
//    abort        cancel the operation in flight (optional feature)
//    ld_reg       load pulse to the wrapper operand registers (Mealy)
//    iter_init    core initialise
//    iter_en      core performs one iteration this cycle
//    iter_count   remaining iterations minus one
//    special_sel  result mux selects the special-value path
//    ld_result    load the result register
//    result_type  latched in_type of the current operation
//    result_flags latched in_flags of the current operation
//    busy         controller not in IDLE
//    valid        result available
//    aborted      one-cycle pulse: operation cancelled
//
// Optional feature macro: SQRT_CTRL_ABORT_EN
//    Defined:   abort in INIT, ITER or WB returns the FSM to IDLE and pulses
//               aborted in the same cycle. No result is loaded or presented.
//    Undefined: abort is ignored and aborted is tied low.
//------------------------------------------------------------------------------
module sqrt_controller #(
   parameter int DP_ITER = 53,
   parameter int SP_ITER = 24,
   parameter int CNT_W   = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             run,
   input  logic             in_type,
   input  logic [2:0]       in_flags,
   input  logic             out_ready,
   input  logic             abort,
   output logic             ld_reg,
   output logic             iter_init,
   output logic             iter_en,
   output logic [CNT_W-1:0] iter_count,
   output logic             special_sel,
   output logic             ld_result,
   output logic             result_type,
   output logic [2:0]       result_flags,
   output logic             busy,
   output logic             valid,
   output logic             aborted
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_ITER    = 3'd2,
      S_WB      = 3'd3,
      S_SPECIAL = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   // The counter is loaded with N-1 and runs down to 0 inclusive. This gives
   // exactly N ITER cycles.
   localparam logic [CNT_W-1:0] DP_LOAD = CNT_W'(DP_ITER - 1);
   localparam logic [CNT_W-1:0] SP_LOAD = CNT_W'(SP_ITER - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             result_type_reg;
   logic [2:0]       result_flags_reg;
   logic             accept_start;
   logic             abort_hit;

   // A start counts only in IDLE. Reset masks the request so that no load
   // pulse escapes while the controller is being cleared.
   assign accept_start = (state_reg == S_IDLE) && start && !rst;

   //---------------------------------------------------------------------------
   // State, counter and operation-attribute registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         cnt_reg          <= '0;
         result_type_reg  <= 1'b0;
         result_flags_reg <= 3'b000;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         // The attributes stay frozen from the IDLE-exit edge until the next
         // accepted start. Downstream logic can therefore read them while the
         // result is held.
         if (accept_start) begin
            result_type_reg  <= in_type;
            result_flags_reg <= in_flags;
         end
      end
   end

   //---------------------------------------------------------------------------
   // Next-state and counter logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      abort_hit  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (accept_start) begin
               state_next = run ? S_INIT : S_SPECIAL;
            end
         end

         S_INIT: begin
            // Use the latched type, not the live input. The wrapper may
            // already show the next operand.
            cnt_next   = result_type_reg ? DP_LOAD : SP_LOAD;
            state_next = S_ITER;
         end

         S_ITER: begin
            if (cnt_reg == '0) begin
               // The last iteration is running now. The counter holds at 0
               // instead of wrapping.
               state_next = S_WB;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end

         S_WB: begin
            state_next = S_HOLD;
         end

         S_SPECIAL: begin
            state_next = S_HOLD;
         end

         S_HOLD: begin
            // start is deliberately not looked at here. A request that
            // coincides with the handshake must be presented again in IDLE.
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

`ifdef SQRT_CTRL_ABORT_EN
      // Cancellation is possible only before the result register is written.
      // SPECIAL and HOLD ignore abort.
      if (abort && !rst &&
          ((state_reg == S_INIT) || (state_reg == S_ITER) || (state_reg == S_WB))) begin
         state_next = S_IDLE;
         abort_hit  = 1'b1;
      end
`endif
   end

   //---------------------------------------------------------------------------
   // Outputs: Moore decodes of the registered state, except ld_reg
   //---------------------------------------------------------------------------
   assign ld_reg       = accept_start;
   assign iter_init    = (state_reg == S_INIT);
   assign iter_en      = (state_reg == S_ITER);
   assign iter_count   = cnt_reg;
   assign special_sel  = (state_reg == S_SPECIAL);
   assign ld_result    = (state_reg == S_WB) || (state_reg == S_SPECIAL);
   assign valid        = (state_reg == S_HOLD);
   assign busy         = (state_reg != S_IDLE);
   assign result_type  = result_type_reg;
   assign result_flags = result_flags_reg;

`ifdef SQRT_CTRL_ABORT_EN
   assign aborted = abort_hit;
`else
   // Without the cancel feature the input has no effect. It stays on the port
   // list so that both builds share one interface.
   assign aborted = abort & abort_hit;
`endif

endmodule

// File: tb/tb_sqrt_controller.sv
//------------------------------------------------------------------------------
// tb_sqrt_controller
//
// Scoreboard bench for sqrt_controller. The stimulus process pushes the
// expected behaviour of each operation before it issues start. The expected
// values are latency, iteration count, path, attributes and valid duration.
// A monitor samples on the falling edge. It pops and compares when the DUT
// completes a handshake or reports a cancellation.
//------------------------------------------------------------------------------
module tb_sqrt_controller;

   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             run;
   logic             in_type;
   logic [2:0]       in_flags;
   logic             out_ready;
   logic             abort;
   logic             ld_reg;
   logic             iter_init;
   logic             iter_en;
   logic [CNT_W-1:0] iter_count;
   logic             special_sel;
   logic             ld_result;
   logic             result_type;
   logic [2:0]       result_flags;
   logic             busy;
   logic             valid;
   logic             aborted;

   always #5 clk = ~clk;

   sqrt_controller #(
      .DP_ITER (53),
      .SP_ITER (24),
      .CNT_W   (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .run          (run),
      .in_type      (in_type),
      .in_flags     (in_flags),
      .out_ready    (out_ready),
      .abort        (abort),
      .ld_reg       (ld_reg),
      .iter_init    (iter_init),
      .iter_en      (iter_en),
      .iter_count   (iter_count),
      .special_sel  (special_sel),
      .ld_result    (ld_result),
      .result_type  (result_type),
      .result_flags (result_flags),
      .busy         (busy),
      .valid        (valid),
      .aborted      (aborted)
   );

   typedef struct {
      bit       typ;
      bit [2:0] flags;
      bit       special;
      int       lat;           // start-edge cycle to first valid cycle
      int       iters;         // expected iter_en pulses
      int       valid_cycles;  // cycles valid is high, including the handshake
      int       abort_at;      // expected aborted cycle, -1 if none
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   //---------------------------------------------------------------------------
   // Monitor
   //---------------------------------------------------------------------------
   bit active = 1'b0;
   int op_start, iter_seen, ldres_seen, valid_seen, first_valid;

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         active = 1'b0;
      end else begin
         if (ld_reg) begin
            if (sb.size() == 0) begin
               check("unexpected_start", 1, 0);
            end else begin
               active      = 1'b1;
               op_start    = cyc;
               iter_seen   = 0;
               ldres_seen  = 0;
               valid_seen  = 0;
               first_valid = -1;
            end
         end
         if (active) begin
            if (iter_en) begin
               if (iter_seen < sb[0].iters)
                  check("iter_count", int'(iter_count), sb[0].iters - 1 - iter_seen);
               iter_seen++;
            end
            if (ld_result) begin
               check("ld_result_cycle", cyc - op_start, sb[0].lat - 1);
               check("special_sel", int'(special_sel), int'(sb[0].special));
               ldres_seen++;
            end
            if (valid) begin
               if (first_valid < 0) first_valid = cyc - op_start;
               valid_seen++;
            end
`ifdef SQRT_CTRL_ABORT_EN
            if (aborted) begin
               check("abort_cycle", cyc - op_start, sb[0].abort_at);
               check("abort_no_ld_result", ldres_seen, 0);
               $display("op aborted type=%0d flags=%03b at cycle %0d, iters %0d",
                        sb[0].typ, sb[0].flags, cyc - op_start, iter_seen);
               void'(sb.pop_front());
               active = 1'b0;
            end
`endif
            if (active && valid && out_ready) begin
               check("valid_latency", first_valid, sb[0].lat);
               check("result_type", int'(result_type), int'(sb[0].typ));
               check("result_flags", int'(result_flags), int'(sb[0].flags));
               check("iter_en_pulses", iter_seen, sb[0].iters);
               check("ld_result_pulses", ldres_seen, 1);
               check("valid_cycles", valid_seen, sb[0].valid_cycles);
               $display("op done type=%0d flags=%03b latency=%0d iters=%0d valid_cycles=%0d",
                        result_type, result_flags, first_valid, iter_seen, valid_seen);
               void'(sb.pop_front());
               active = 1'b0;
            end
         end else if (ld_result || valid || iter_en) begin
            check("unexpected_output", 1, 0);
         end
`ifndef SQRT_CTRL_ABORT_EN
         if (aborted) check("aborted_tied_low", int'(aborted), 0);
`endif
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus helpers
   //---------------------------------------------------------------------------
   task automatic wait_idle();
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while ((busy || sb.size() != 0) && k < 200);
      check("op_completes", (busy || sb.size() != 0) ? 0 : 1, 1);
      @(posedge clk) #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_ld_reg"}, int'(ld_reg), 0);
      check({tag, "_iter_count"}, int'(iter_count), 0);
      check({tag, "_result_type"}, int'(result_type), 0);
      check({tag, "_result_flags"}, int'(result_flags), 0);
      check({tag, "_strobes"}, int'({iter_init, iter_en, special_sel, ld_result, aborted}), 0);
   endtask

   // Issues one operation. Hand-computed timing: normal DP latency 56 with
   // 53 iterations, normal SP latency 27 with 24 iterations, special latency
   // 2 with no iterations. bp > 0 holds out_ready low for bp HOLD cycles.
   task automatic do_op(input bit typ, input bit r, input bit [2:0] fl,
                        input int abort_at, input int bp);
      exp_t e;
      e.typ          = typ;
      e.flags        = fl;
      e.special      = !r;
      e.iters        = r ? (typ ? 53 : 24) : 0;
      e.lat          = r ? (typ ? 56 : 27) : 2;
      e.valid_cycles = bp + 1;
      e.abort_at     = -1;
`ifdef SQRT_CTRL_ABORT_EN
      if (abort_at >= 0) begin
         e.abort_at = abort_at;
         e.lat      = -1;
      end
`endif
      sb.push_back(e);
      out_ready = (bp == 0);
      start     = 1'b1;
      in_type   = typ;
      run       = r;
      in_flags  = fl;
      @(posedge clk) #1;
      // Scramble the live inputs to show the controller uses the latched copy.
      start    = 1'b0;
      in_type  = ~typ;
      run      = ~r;
      in_flags = ~fl;
      if (abort_at > 0) begin
         repeat (abort_at - 1) @(posedge clk);
         #1 abort = 1'b1;
         @(posedge clk) #1 abort = 1'b0;
      end
      if (bp > 0) begin
         int k = 0;
         while (!valid && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("hold_reached", int'(valid), 1);
         for (int i = 1; i < bp; i++) begin
            @(posedge clk) #1;
            start = (i == bp / 2);       // start during HOLD must be ignored
         end
         @(posedge clk) #1;
         out_ready = 1'b1;
         start     = 1'b1;               // coincides with the handshake: ignored
         @(posedge clk) #1;
         start = 1'b0;
         @(negedge clk);
         check("idle_after_hold_busy", int'(busy), 0);
         check("idle_after_hold_valid", int'(valid), 0);
      end
      wait_idle();
   endtask

   //---------------------------------------------------------------------------
   // Main sequence
   //---------------------------------------------------------------------------
   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      run       = 1'b0;
      in_type   = 1'b0;
      in_flags  = 3'b000;
      out_ready = 1'b1;
      abort     = 1'b0;

      // Power-on reset with start asserted: everything must stay low.
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check_cleared("por");
      @(posedge clk) #1;
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk) #1;

      // Normal operands
      do_op(1'b1, 1'b1, 3'b100, -1, 0);   // DP
      do_op(1'b0, 1'b1, 3'b100, -1, 0);   // SP
      do_op(1'b0, 1'b1, 3'b000, -1, 0);   // SP, denormal class on the core path

      // Special operands on the bypass path
      do_op(1'b1, 1'b0, 3'b001, -1, 0);
      do_op(1'b0, 1'b0, 3'b010, -1, 0);
      do_op(1'b1, 1'b0, 3'b011, -1, 0);
      do_op(1'b0, 1'b0, 3'b111, -1, 0);

      // Backpressure: 10 cycles with out_ready low, stray starts in HOLD
      do_op(1'b0, 1'b1, 3'b100, -1, 10);
      do_op(1'b1, 1'b0, 3'b010, -1, 10);

      // Reset mid-ITER of a DP operation
      begin
         exp_t e;
         int   ev;
         e.typ = 1'b1; e.flags = 3'b100; e.special = 1'b0;
         e.lat = 56; e.iters = 53; e.valid_cycles = 1; e.abort_at = -1;
         sb.push_back(e);
         start = 1'b1; in_type = 1'b1; run = 1'b1; in_flags = 3'b100;
         @(posedge clk) #1 start = 1'b0;
         repeat (19) @(posedge clk);
         #1 rst = 1'b1;
         start = 1'b1;
         @(posedge clk) #1;
         @(negedge clk);
         check_cleared("mid_reset");
         @(posedge clk) #1;
         rst   = 1'b0;
         start = 1'b0;
         ev = 0;
         for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (ld_result || valid || busy || iter_en) ev++;
         end
         check("post_reset_quiet", ev, 0);
         @(posedge clk) #1;
      end

      // Cancel at cycle 20 of a DP operation, then an SP operation. In the
      // default build the cancel request is ignored and the DP op completes.
      do_op(1'b1, 1'b1, 3'b100, 20, 0);
      do_op(1'b0, 1'b1, 3'b100, -1, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sqrt_controller.md
Name: sqrt_controller

Overview:
- FSM that sequences the double/single-precision square-root datapath.
- Accepts a start request and drives the operand-register load (ld_reg) of the sqrt input wrapper.
- Normal operands: runs the digit-recurrence core for a type-dependent iteration count. Special operands: takes a one-cycle bypass path.
- Presents the result to the downstream consumer with a valid/ready handshake.

Parameters:
- DP_ITER, 53, core iterations for double precision (in_type=1)
- SP_ITER, 24, core iterations for single precision (in_type=0)
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(DP_ITER, SP_ITER)

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a new sqrt operation
- run  input  1  from input wrapper: 1 = normal positive operand, use the core
- in_type  input  1  0 = single, 1 = double
- in_flags  input  3  wrapper out_flags (sign-merged): 000 denormal, 001 zero, 010 inf, 011 nan, 100 normal, 111 sign error
- out_ready  input  1  downstream accepts the result
- abort  input  1  cancel the operation in flight (used only with the optional feature)
- ld_reg  output  1  load pulse to the wrapper mantissa/exponent registers
- iter_init  output  1  core initialise (remainder/root clear)
- iter_en  output  1  core performs one iteration this cycle
- iter_count  output  CNT_W  remaining iterations minus one
- special_sel  output  1  result mux selects the special-value path
- ld_result  output  1  load the result register
- result_type  output  1  latched in_type of the current operation
- result_flags  output  3  latched in_flags of the current operation
- busy  output  1  controller not in IDLE
- valid  output  1  result available
- aborted  output  1  one-cycle pulse: operation cancelled

Behaviour:
- States: IDLE, INIT, ITER, WB, SPECIAL, HOLD.
- Reset:
  - state=IDLE; counter, result_type and result_flags = 0.
  - All outputs 0.
  - Reset asserted in any state returns to IDLE at that edge; no valid is issued and no result is loaded.
- IDLE:
  - busy=0. ld_reg = start (combinational, IDLE only).
  - On start: latch in_type into result_type and in_flags into result_flags.
  - Next state is INIT if run=1, otherwise SPECIAL.
- INIT:
  - iter_init=1.
  - Counter loaded with DP_ITER-1 if result_type=1, SP_ITER-1 otherwise.
  - Next state ITER.
- ITER:
  - iter_en=1 every cycle.
  - Counter decrements; iter_count shows the counter value.
  - When counter==0 in ITER, next state is WB; no wrap.
- WB: ld_result=1, special_sel=0. Next state HOLD.
- SPECIAL: ld_result=1, special_sel=1. Next state HOLD.
- HOLD:
  - valid=1; held until out_ready=1.
  - valid&out_ready: next state IDLE.
  - start is not sampled outside IDLE. A start in the same cycle as the handshake is ignored and must be re-presented in IDLE.
- Latency, counting cycle 0 as the start edge in IDLE:
  - Normal: valid first high at cycle N+3, i.e. 56 for DP and 27 for SP.
  - Special: valid first high at cycle 2.
- Decode rules:
  - iter_en, iter_init, ld_result, special_sel, valid and busy are Moore decodes of the registered state.
  - ld_reg is the only Mealy output.
- result_type and result_flags stay stable from the IDLE-exit edge until the next accepted start.
- Exactly one ld_result pulse occurs per accepted start; no iter_en is issued on the special path.

Optional Feature:
- Macro: SQRT_CTRL_ABORT_EN.
- Defined:
  - abort=1 in INIT, ITER or WB forces next state to IDLE. aborted pulses 1 in that cycle.
  - No ld_result or valid follows.
  - abort in IDLE, SPECIAL or HOLD is ignored.
  - rst has priority over abort.
- Undefined: abort is ignored; aborted is constant 0; FSM as above.

Test Plan:
- Reset: rst=1 for 2 cycles mid-ITER (DP) -> state IDLE, busy=0, valid=0, no ld_result pulse after reset.
- DP normal: in_type=1, run=1, flags=100, start at cycle 0, out_ready=1 -> ld_reg at cycle 0, iter_init at cycle 1, iter_en cycles 2..54 (53 pulses, iter_count 52..0), ld_result at cycle 55, valid at cycle 56 for 1 cycle.
- SP normal: in_type=0, run=1 -> 24 iter_en pulses, valid at cycle 27, result_type=0.
- Specials: flags 001, 010, 011 and 111 (run=0) -> special_sel=ld_result=1 at cycle 1, valid at cycle 2, result_flags equals the input code, zero iter_en pulses.
- Backpressure: out_ready=0 for 10 cycles in HOLD, start pulsed during HOLD -> valid held for 10 cycles, extra start ignored; after out_ready=1 the FSM returns to IDLE, busy=0.
- Abort (SQRT_CTRL_ABORT_EN defined): abort at cycle 20 of a DP op -> aborted=1 at cycle 20, IDLE at cycle 21, no valid. A new SP op then completes normally with valid at cycle 27 relative to its start.
